// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, constants and address check for the data-memory responder
//
// Contents:
//   state_t     responder FSM states (IDLE, WAIT, RESP)
//   WORD_BYTES  bytes per transferred word
//   addr_err()  returns 1 when a word address is misaligned or beyond the store
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned WORD_BYTES = 4;

    // Full 32-bit compare: high address bits never alias onto the store.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || (addr > (depth - WORD_BYTES));
    endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// rtl/dmem_byte_array.sv - byte-addressed big-endian word store with async clear
//
// Ports:
//   clk    in   clock, writes on rising edge
//   reset  in   asynchronous active-low clear of every byte
//   we     in   word write enable
//   addr   in   byte address of the word (aligned, in range when we=1)
//   wdata  in   word to write, wdata[31:24] lands at addr
//   rdata  out  combinational word read at addr, mem[addr] in rdata[31:24]
module dmem_byte_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = 128,
    parameter int unsigned AW          = $clog2(DEPTH_BYTES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [7:0]    mem [DEPTH_BYTES];
    logic [AW-1:0] i0, i1, i2, i3;

    assign i0 = addr;
    assign i1 = addr + AW'(1);
    assign i2 = addr + AW'(2);
    assign i3 = addr + AW'(3);

    assign rdata = {mem[i0], mem[i1], mem[i2], mem[i3]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < int'(DEPTH_BYTES); k++) begin
                mem[k] <= 8'h00;
            end
        end else if (we) begin
            mem[i0] <= wdata[31:24];
            mem[i1] <= wdata[23:16];
            mem[i2] <= wdata[15:8];
            mem[i3] <= wdata[7:0];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle load/store responder with programmable wait states
//
// Ports:
//   clk        in   clock
//   reset      in   asynchronous active-low reset
//   req_valid  in   request present
//   req_we     in   1 = store word, 0 = load word
//   req_addr   in   byte address
//   req_wdata  in   store data
//   req_ready  out  request accepted this cycle (high only in IDLE)
//   rsp_valid  out  response available (high only in RESP)
//   rsp_ready  in   response consumed
//   rsp_rdata  out  load data, 0 for stores and errors
//   rsp_err    out  misaligned or out-of-range request
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = 128,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW      = $clog2(DEPTH_BYTES);
    localparam logic [3:0]  WS_LAST = 4'(WAIT_STATES);

    state_t      state, next_state;
    logic [3:0]  cnt;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        accept;
    logic        commit;
    logic        err_now;
    logic        mem_we;
    logic [31:0] rd_word;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign err_now   = addr_err(lat_addr, DEPTH_BYTES);
    assign mem_we    = commit && lat_we && !err_now;

    // WAIT always lasts WAIT_STATES+1 cycles: the first one is the cycle in
    // which the just-latched request settles, so the response is built only
    // from registered request fields, never from the live request bus.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (cnt == WS_LAST) begin
                    commit     = 1'b1;
                    next_state = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
            end
            if (state == WAIT) begin
                cnt <= commit ? 4'd0 : cnt + 4'd1;
            end
            if (commit) begin
                rsp_err   <= err_now;
                rsp_rdata <= (!lat_we && !err_now) ? rd_word : 32'd0;
            end
        end
    end

    dmem_byte_array #(
        .DEPTH_BYTES (DEPTH_BYTES),
        .AW          (AW)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we),
        .addr  (lat_addr[AW-1:0]),
        .wdata (lat_wdata),
        .rdata (rd_word)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;

    logic        req_valid, req_we, req_ready, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;

    logic        req_valid0, req_we0, req_ready0, rsp_valid0, rsp_ready0, rsp_err0;
    logic [31:0] req_addr0, req_wdata0, rsp_rdata0;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_BYTES(128), .WAIT_STATES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    dmem_responder #(.DEPTH_BYTES(128), .WAIT_STATES(0)) dut0 (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid0),
        .req_we    (req_we0),
        .req_addr  (req_addr0),
        .req_wdata (req_wdata0),
        .req_ready (req_ready0),
        .rsp_valid (rsp_valid0),
        .rsp_ready (rsp_ready0),
        .rsp_rdata (rsp_rdata0),
        .rsp_err   (rsp_err0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction on the WAIT_STATES=2 instance with rsp_ready high.
    // lat = clock edges from the accepting edge until rsp_valid is seen.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat);
        int n;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        tick();
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'h0BAD_0BAD;
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        lat   = n;
        rdata = rsp_rdata;
        err   = rsp_err;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        tests_run++;
        if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        tests_run++;
        if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        tests_run++;
        if (rsp_rdata !== 32'd0) begin tests_failed++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
        tests_run++;
        if (rsp_err !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
        reset = 1'b1;
        tick();
        tests_run++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_idle: req_ready=%b rsp_valid=%b want 1/0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(1'b1, 32'h08, 32'h1234_5678, rd, er, lat);
        tests_run++;
        if (lat !== 3) begin tests_failed++; $display("FAIL store_latency: got %0d want 3", lat); end
        tests_run++;
        if (er !== 1'b0 || rd !== 32'd0) begin tests_failed++; $display("FAIL store_rsp: err=%b rdata=%h want 0/0", er, rd); end
        do_req(1'b0, 32'h08, 32'h0, rd, er, lat);
        tests_run++;
        if (rd !== 32'h1234_5678 || er !== 1'b0) begin tests_failed++; $display("FAIL load_08: rdata=%h err=%b want 12345678/0", rd, er); end
        tests_run++;
        if (lat !== 3) begin tests_failed++; $display("FAIL load_latency: got %0d want 3", lat); end
        tests_run++;
        if (dut.u_mem.mem[8] !== 8'h12) begin tests_failed++; $display("FAIL byte_08: got %h want 12", dut.u_mem.mem[8]); end
        tests_run++;
        if (dut.u_mem.mem[11] !== 8'h78) begin tests_failed++; $display("FAIL byte_0b: got %h want 78", dut.u_mem.mem[11]); end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(1'b1, 32'h7C, 32'hDEAD_BEEF, rd, er, lat);
        tests_run++;
        if (er !== 1'b0) begin tests_failed++; $display("FAIL store_7c_err: got %b want 0", er); end
        do_req(1'b0, 32'h7C, 32'h0, rd, er, lat);
        tests_run++;
        if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin tests_failed++; $display("FAIL load_7c: rdata=%h err=%b want deadbeef/0", rd, er); end
        do_req(1'b1, 32'h7E, 32'h1122_3344, rd, er, lat);
        tests_run++;
        if (er !== 1'b1 || rd !== 32'd0) begin tests_failed++; $display("FAIL store_7e: err=%b rdata=%h want 1/0", er, rd); end
        do_req(1'b0, 32'h7C, 32'h0, rd, er, lat);
        tests_run++;
        if (rd !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL store_7e_no_write: rdata=%h want deadbeef", rd); end
        tests_run++;
        if (dut.u_mem.mem[124] !== 8'hDE || dut.u_mem.mem[127] !== 8'hEF) begin
            tests_failed++;
            $display("FAIL bytes_7c_7f: got %h..%h want de..ef", dut.u_mem.mem[124], dut.u_mem.mem[127]);
        end
        do_req(1'b0, 32'h06, 32'h0, rd, er, lat);
        tests_run++;
        if (er !== 1'b1 || rd !== 32'd0) begin tests_failed++; $display("FAIL load_06: err=%b rdata=%h want 1/0", er, rd); end
        do_req(1'b0, 32'h80, 32'h0, rd, er, lat);
        tests_run++;
        if (er !== 1'b1 || rd !== 32'd0) begin tests_failed++; $display("FAIL load_80: err=%b rdata=%h want 1/0", er, rd); end
        do_req(1'b0, 32'h88, 32'h0, rd, er, lat);
        tests_run++;
        if (er !== 1'b1 || rd !== 32'd0) begin tests_failed++; $display("FAIL load_88_alias: err=%b rdata=%h want 1/0", er, rd); end
    endtask

    task automatic test_hold();
        int n;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h08;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        tests_run++;
        if (n !== 3) begin tests_failed++; $display("FAIL hold_latency: got %0d want 3", n); end
        for (int i = 0; i < 5; i++) begin
            req_valid = ~req_valid;
            req_addr  = 32'(i * 4);
            tick();
            tests_run++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== 32'h1234_5678) begin
                tests_failed++;
                $display("FAIL hold_cycle%0d: rsp_valid=%b req_ready=%b rdata=%h want 1/0/12345678",
                         i, rsp_valid, req_ready, rsp_rdata);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        tests_run++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL hold_release: rsp_valid=%b req_ready=%b want 0/1", rsp_valid, req_ready);
        end
        tests_run++;
        if (rsp_rdata !== 32'h1234_5678) begin tests_failed++; $display("FAIL rdata_kept: got %h want 12345678", rsp_rdata); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic        er;
        int          lat;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h10;
        req_wdata = 32'hAAAA_AAAA;
        tick();
        req_valid = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        tests_run++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_outputs: ready=%b valid=%b rdata=%h err=%b want 1/0/0/0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        tick();
        reset = 1'b1;
        tick();
        tests_run++;
        if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_rsp_lost: rsp_valid=%b want 0", rsp_valid); end
        do_req(1'b0, 32'h10, 32'h0, rd, er, lat);
        tests_run++;
        if (rd !== 32'd0 || er !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_load_10: rdata=%h err=%b want 0/0", rd, er); end
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int rsp[$];
        int n;
        req_valid0 = 1'b1;
        req_we0    = 1'b1;
        req_addr0  = 32'h04;
        req_wdata0 = 32'hCAFE_F00D;
        tick();
        req_valid0 = 1'b0;
        n = 0;
        while (!rsp_valid0 && n < 20) begin
            tick();
            n++;
        end
        tests_run++;
        if (n !== 1 || rsp_err0 !== 1'b0) begin tests_failed++; $display("FAIL ws0_store: latency=%0d err=%b want 1/0", n, rsp_err0); end
        tick();
        req_valid0 = 1'b1;
        req_we0    = 1'b0;
        req_addr0  = 32'h04;
        for (int i = 0; i < 12; i++) begin
            if (req_ready0) acc.push_back(i);
            tick();
            if (rsp_valid0) begin
                rsp.push_back(i);
                tests_run++;
                if (rsp_rdata0 !== 32'hCAFE_F00D || rsp_err0 !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL b2b_data_c%0d: rdata=%h err=%b want cafef00d/0", i, rsp_rdata0, rsp_err0);
                end
            end
        end
        req_valid0 = 1'b0;
        tests_run++;
        if (acc.size() !== 4 || rsp.size() !== 4) begin
            tests_failed++;
            $display("FAIL b2b_counts: accepts=%0d responses=%0d want 4/4", acc.size(), rsp.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                tests_run++;
                if (acc[k] !== 3 * k || rsp[k] !== 3 * k + 1) begin
                    tests_failed++;
                    $display("FAIL b2b_timing%0d: accept=%0d response=%0d want %0d/%0d", k, acc[k], rsp[k], 3 * k, 3 * k + 1);
                end
            end
        end
    endtask

    initial begin
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        rsp_ready  = 1'b1;
        req_valid0 = 1'b0;
        req_we0    = 1'b0;
        req_addr0  = 32'd0;
        req_wdata0 = 32'd0;
        rsp_ready0 = 1'b1;
        test_reset();
        test_store_load();
        test_errors();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
